// File: rtl/compute_job_arbiter.sv
// Round-robin arbiter sharing one compute engine between N_REQ requesters.
// It sequences the engine start/done handshake and routes the owner's A/B/C streams.
module compute_job_arbiter #(
    parameter int DATA_W      = 32,
    parameter int N_REQ       = 2,
    parameter int K_W         = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_start,
    input  logic [N_REQ*K_W-1:0]     req_cfg_k,
    output logic [N_REQ-1:0]         req_grant,
    output logic [N_REQ-1:0]         req_done,
    output logic [N_REQ-1:0]         req_err,
    output logic [K_W-1:0]           eng_cfg_k,
    output logic                     eng_start,
    input  logic                     eng_done,
    input  logic [N_REQ*DATA_W-1:0]  s_axis_a_tdata,
    input  logic [N_REQ-1:0]         s_axis_a_tvalid,
    input  logic [N_REQ-1:0]         s_axis_a_tlast,
    output logic [N_REQ-1:0]         s_axis_a_tready,
    input  logic [N_REQ*DATA_W-1:0]  s_axis_b_tdata,
    input  logic [N_REQ-1:0]         s_axis_b_tvalid,
    input  logic [N_REQ-1:0]         s_axis_b_tlast,
    output logic [N_REQ-1:0]         s_axis_b_tready,
    output logic [DATA_W-1:0]        m_axis_a_tdata,
    output logic                     m_axis_a_tvalid,
    output logic                     m_axis_a_tlast,
    input  logic                     m_axis_a_tready,
    output logic [DATA_W-1:0]        m_axis_b_tdata,
    output logic                     m_axis_b_tvalid,
    output logic                     m_axis_b_tlast,
    input  logic                     m_axis_b_tready,
    input  logic [DATA_W-1:0]        s_axis_c_tdata,
    input  logic                     s_axis_c_tvalid,
    input  logic                     s_axis_c_tlast,
    output logic                     s_axis_c_tready,
    output logic [DATA_W-1:0]        m_axis_c_tdata,
    output logic [N_REQ-1:0]         m_axis_c_tvalid,
    output logic [N_REQ-1:0]         m_axis_c_tlast,
    input  logic [N_REQ-1:0]         m_axis_c_tready
);

    localparam int OW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RELEASE} state_t;

    state_t           state;
    logic [OW-1:0]    owner;
    logic [OW-1:0]    last_owner;
    logic [WD_W-1:0]  wd_cnt;
    logic             any_req;
    logic [OW-1:0]    pick;
    logic [OW-1:0]    cand;

    logic [K_W-1:0]    cfg_arr [N_REQ];
    logic [DATA_W-1:0] a_arr   [N_REQ];
    logic [DATA_W-1:0] b_arr   [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign cfg_arr[g] = req_cfg_k[g*K_W +: K_W];
        assign a_arr[g]   = s_axis_a_tdata[g*DATA_W +: DATA_W];
        assign b_arr[g]   = s_axis_b_tdata[g*DATA_W +: DATA_W];
    end

    // Scan from the farthest rotated slot down so the one right after last_owner wins.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = OW'((int'(last_owner) + 1 + i) % N_REQ);
            if (req_start[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    // NOTE: async reset lives in the sensitivity list, so grant and eng_start drop without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(N_REQ - 1);
            wd_cnt     <= '0;
            req_grant  <= '0;
            req_done   <= '0;
            req_err    <= '0;
            eng_cfg_k  <= '0;
            eng_start  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values regardless of order.
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: if (any_req) begin
                    owner     <= pick;
                    eng_cfg_k <= cfg_arr[pick];
                    req_grant <= ONE << pick;
                    // Rejection is raised here so the pulse is visible during LOAD itself.
                    if (cfg_arr[pick] == '0) req_err <= ONE << pick;
                    state     <= LOAD;
                end
                LOAD: if (eng_cfg_k == '0) begin
                    req_grant  <= '0;
                    last_owner <= owner;
                    state      <= IDLE;
                end else begin
                    eng_start <= 1'b1;
                    wd_cnt    <= '0;
                    state     <= RUN;
                end
                RUN: if (eng_done) begin
                    req_done  <= req_grant;
                    eng_start <= 1'b0;
                    state     <= RELEASE;
                end else if ((TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST)) begin
                    req_err   <= req_grant;
                    eng_start <= 1'b0;
                    state     <= RELEASE;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                RELEASE: if (!eng_done) begin
                    last_owner <= owner;
                    req_grant  <= '0;
                    wd_cnt     <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stream routing is purely combinational and only open while the engine runs.
    always_comb begin
        s_axis_a_tready = '0;
        s_axis_b_tready = '0;
        m_axis_a_tdata  = '0;
        m_axis_a_tvalid = 1'b0;
        m_axis_a_tlast  = 1'b0;
        m_axis_b_tdata  = '0;
        m_axis_b_tvalid = 1'b0;
        m_axis_b_tlast  = 1'b0;
        s_axis_c_tready = 1'b0;
        m_axis_c_tdata  = '0;
        m_axis_c_tvalid = '0;
        m_axis_c_tlast  = '0;
        if (state == RUN) begin
            m_axis_a_tdata         = a_arr[owner];
            m_axis_a_tvalid        = s_axis_a_tvalid[owner];
            m_axis_a_tlast         = s_axis_a_tlast[owner];
            s_axis_a_tready[owner] = m_axis_a_tready;
            m_axis_b_tdata         = b_arr[owner];
            m_axis_b_tvalid        = s_axis_b_tvalid[owner];
            m_axis_b_tlast         = s_axis_b_tlast[owner];
            s_axis_b_tready[owner] = m_axis_b_tready;
            m_axis_c_tdata         = s_axis_c_tdata;
            m_axis_c_tvalid[owner] = s_axis_c_tvalid;
            m_axis_c_tlast[owner]  = s_axis_c_tlast;
            s_axis_c_tready        = m_axis_c_tready[owner];
        end
    end

endmodule

// File: tb/tb_compute_job_arbiter.sv
// Directed bench for compute_job_arbiter: the engine and requesters are driven by hand,
// with expected values worked out cycle by cycle.
module tb_compute_job_arbiter;

    localparam int DATA_W      = 32;
    localparam int N_REQ       = 2;
    localparam int K_W         = 16;
    localparam int TIMEOUT_CYC = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_REQ-1:0]        req_start;
    logic [N_REQ*K_W-1:0]    req_cfg_k;
    logic [N_REQ-1:0]        req_grant, req_done, req_err;
    logic [K_W-1:0]          eng_cfg_k;
    logic                    eng_start, eng_done;
    logic [N_REQ*DATA_W-1:0] s_axis_a_tdata, s_axis_b_tdata;
    logic [N_REQ-1:0]        s_axis_a_tvalid, s_axis_a_tlast, s_axis_a_tready;
    logic [N_REQ-1:0]        s_axis_b_tvalid, s_axis_b_tlast, s_axis_b_tready;
    logic [DATA_W-1:0]       m_axis_a_tdata, m_axis_b_tdata;
    logic                    m_axis_a_tvalid, m_axis_a_tlast, m_axis_a_tready;
    logic                    m_axis_b_tvalid, m_axis_b_tlast, m_axis_b_tready;
    logic [DATA_W-1:0]       s_axis_c_tdata, m_axis_c_tdata;
    logic                    s_axis_c_tvalid, s_axis_c_tlast, s_axis_c_tready;
    logic [N_REQ-1:0]        m_axis_c_tvalid, m_axis_c_tlast, m_axis_c_tready;

    int checks = 0;
    int errors = 0;

    compute_job_arbiter #(
        .DATA_W(DATA_W), .N_REQ(N_REQ), .K_W(K_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_start(req_start), .req_cfg_k(req_cfg_k),
        .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
        .eng_cfg_k(eng_cfg_k), .eng_start(eng_start), .eng_done(eng_done),
        .s_axis_a_tdata(s_axis_a_tdata), .s_axis_a_tvalid(s_axis_a_tvalid),
        .s_axis_a_tlast(s_axis_a_tlast), .s_axis_a_tready(s_axis_a_tready),
        .s_axis_b_tdata(s_axis_b_tdata), .s_axis_b_tvalid(s_axis_b_tvalid),
        .s_axis_b_tlast(s_axis_b_tlast), .s_axis_b_tready(s_axis_b_tready),
        .m_axis_a_tdata(m_axis_a_tdata), .m_axis_a_tvalid(m_axis_a_tvalid),
        .m_axis_a_tlast(m_axis_a_tlast), .m_axis_a_tready(m_axis_a_tready),
        .m_axis_b_tdata(m_axis_b_tdata), .m_axis_b_tvalid(m_axis_b_tvalid),
        .m_axis_b_tlast(m_axis_b_tlast), .m_axis_b_tready(m_axis_b_tready),
        .s_axis_c_tdata(s_axis_c_tdata), .s_axis_c_tvalid(s_axis_c_tvalid),
        .s_axis_c_tlast(s_axis_c_tlast), .s_axis_c_tready(s_axis_c_tready),
        .m_axis_c_tdata(m_axis_c_tdata), .m_axis_c_tvalid(m_axis_c_tvalid),
        .m_axis_c_tlast(m_axis_c_tlast), .m_axis_c_tready(m_axis_c_tready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_start       = '0;
        req_cfg_k       = '0;
        eng_done        = 1'b0;
        s_axis_a_tdata  = '0; s_axis_a_tvalid = '0; s_axis_a_tlast = '0;
        s_axis_b_tdata  = '0; s_axis_b_tvalid = '0; s_axis_b_tlast = '0;
        m_axis_a_tready = 1'b0;
        m_axis_b_tready = 1'b0;
        s_axis_c_tdata  = '0; s_axis_c_tvalid = 1'b0; s_axis_c_tlast = 1'b0;
        m_axis_c_tready = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        checks++; if (req_grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", req_grant); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL rst_eng_start: got %b want 0", eng_start); end
        checks++; if (req_done !== 2'b00 || req_err !== 2'b00) begin errors++; $display("FAIL rst_pulses: done %b err %b want 00 00", req_done, req_err); end
        checks++; if (eng_cfg_k !== 16'd0) begin errors++; $display("FAIL rst_cfg_k: got %0d want 0", eng_cfg_k); end
        checks++; if (s_axis_a_tready !== 2'b00 || m_axis_c_tvalid !== 2'b00 || s_axis_c_tready !== 1'b0) begin
            errors++; $display("FAIL rst_streams: a_rdy %b c_vld %b c_rdy %b want 0", s_axis_a_tready, m_axis_c_tvalid, s_axis_c_tready); end
    endtask

    task automatic test_single_job();
        int c0 = 0;
        int c1 = 0;
        req_cfg_k = {16'd0, 16'd4};
        req_start = 2'b01;
        step();
        checks++; if (req_grant !== 2'b01) begin errors++; $display("FAIL single_load_grant: got %b want 01", req_grant); end
        checks++; if (eng_cfg_k !== 16'd4) begin errors++; $display("FAIL single_cfg_k: got %0d want 4", eng_cfg_k); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL single_load_start: got %b want 0", eng_start); end
        step();
        checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL single_run_start: got %b want 1", eng_start); end
        s_axis_a_tdata = {32'h0, 32'hA}; s_axis_a_tvalid = 2'b01; s_axis_a_tlast = 2'b01;
        s_axis_b_tdata = {32'hBAD, 32'hB}; s_axis_b_tvalid = 2'b11; s_axis_b_tlast = 2'b11;
        m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
        #1;
        checks++; if (m_axis_a_tvalid !== 1'b1 || m_axis_a_tdata !== 32'hA || m_axis_a_tlast !== 1'b1) begin
            errors++; $display("FAIL single_a_route: vld %b data %h last %b want 1 a 1", m_axis_a_tvalid, m_axis_a_tdata, m_axis_a_tlast); end
        checks++; if (m_axis_b_tvalid !== 1'b1 || m_axis_b_tdata !== 32'hB) begin
            errors++; $display("FAIL single_b_route: vld %b data %h want 1 b", m_axis_b_tvalid, m_axis_b_tdata); end
        checks++; if (s_axis_a_tready !== 2'b01 || s_axis_b_tready !== 2'b01) begin
            errors++; $display("FAIL single_ab_ready: a %b b %b want 01 01", s_axis_a_tready, s_axis_b_tready); end
        step();
        s_axis_a_tvalid = '0; s_axis_b_tvalid = '0;
        m_axis_c_tready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            s_axis_c_tvalid = 1'b1;
            s_axis_c_tdata  = 32'hC0 + i;
            s_axis_c_tlast  = (i == 3);
            #1;
            if (m_axis_c_tvalid[0] && m_axis_c_tready[0] && s_axis_c_tready) c0++;
            if (m_axis_c_tvalid[1]) c1++;
            checks++; if (m_axis_c_tlast !== {1'b0, (i == 3)}) begin
                errors++; $display("FAIL single_c_last: beat %0d got %b want %b", i, m_axis_c_tlast, {1'b0, (i == 3)}); end
            step();
        end
        s_axis_c_tvalid = 1'b0; s_axis_c_tlast = 1'b0;
        checks++; if (c0 !== 4 || c1 !== 0) begin errors++; $display("FAIL single_c_count: req0 %0d req1 %0d want 4 0", c0, c1); end
        eng_done = 1'b1;
        step();
        checks++; if (req_done !== 2'b01 || req_err !== 2'b00) begin errors++; $display("FAIL single_done: done %b err %b want 01 00", req_done, req_err); end
        checks++; if (eng_start !== 1'b0 || s_axis_c_tready !== 1'b0) begin errors++; $display("FAIL single_release: start %b c_rdy %b want 0 0", eng_start, s_axis_c_tready); end
        req_start = '0;
        eng_done  = 1'b0;
        step();
        checks++; if (req_done !== 2'b00 || req_grant !== 2'b00) begin errors++; $display("FAIL single_idle: done %b grant %b want 00 00", req_done, req_grant); end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_cfg_k = {16'd2, 16'd4};
        req_start = 2'b11;
        step();
        checks++; if (req_grant !== 2'b01 || eng_cfg_k !== 16'd4) begin errors++; $display("FAIL rr_first: grant %b k %0d want 01 4", req_grant, eng_cfg_k); end
        step();
        s_axis_a_tvalid = 2'b11; s_axis_b_tvalid = 2'b11;
        m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
        #1;
        checks++; if (s_axis_a_tready !== 2'b01 || s_axis_b_tready !== 2'b01) begin
            errors++; $display("FAIL rr_block_req1: a %b b %b want 01 01", s_axis_a_tready, s_axis_b_tready); end
        eng_done = 1'b1;
        step();
        checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL rr_done0: got %b want 01", req_done); end
        eng_done = 1'b0;
        step();
        checks++; if (req_grant !== 2'b00) begin errors++; $display("FAIL rr_gap: grant %b want 00", req_grant); end
        step();
        checks++; if (req_grant !== 2'b10 || eng_cfg_k !== 16'd2) begin errors++; $display("FAIL rr_second: grant %b k %0d want 10 2", req_grant, eng_cfg_k); end
        step();
        #1;
        checks++; if (s_axis_a_tready !== 2'b10) begin errors++; $display("FAIL rr_route_req1: a_rdy %b want 10", s_axis_a_tready); end
        eng_done = 1'b1;
        step();
        checks++; if (req_done !== 2'b10) begin errors++; $display("FAIL rr_done1: got %b want 10", req_done); end
        eng_done = 1'b0;
        repeat (2) step();
        checks++; if (req_grant !== 2'b01) begin errors++; $display("FAIL rr_third: grant %b want 01", req_grant); end
        step();
        eng_done = 1'b1;
        step();
        req_start = '0;
        eng_done  = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic test_c_stall();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic [1:0] r;
        req_cfg_k = {16'd0, 16'd4};
        req_start = 2'b01;
        repeat (2) step();
        checks++; if (eng_start !== 1'b1 || req_grant !== 2'b01) begin errors++; $display("FAIL stall_run: start %b grant %b want 1 01", eng_start, req_grant); end
        while (sent < 4 && cyc < 200) begin
            r = 2'($urandom_range(0, 3));
            m_axis_c_tready = r;
            s_axis_c_tvalid = 1'b1;
            s_axis_c_tdata  = 32'h100 + sent;
            s_axis_c_tlast  = (sent == 3);
            #1;
            checks++; if (s_axis_c_tready !== r[0]) begin errors++; $display("FAIL stall_mirror: c_rdy %b want %b", s_axis_c_tready, r[0]); end
            if (m_axis_c_tvalid[0] && m_axis_c_tready[0]) begin
                checks++; if (m_axis_c_tdata !== 32'h100 + got) begin errors++; $display("FAIL stall_order: got %h want %h", m_axis_c_tdata, 32'h100 + got); end
                got++;
            end
            if (m_axis_c_tvalid[1]) begin checks++; errors++; $display("FAIL stall_nonowner: c_vld %b want 01", m_axis_c_tvalid); end
            if (s_axis_c_tvalid && s_axis_c_tready) sent++;
            cyc++;
            step();
        end
        s_axis_c_tvalid = 1'b0; s_axis_c_tlast = 1'b0;
        checks++; if (cyc >= 200) begin errors++; $display("FAIL stall_timeout: sent %0d after %0d cycles want 4", sent, cyc); end
        checks++; if (got !== 4) begin errors++; $display("FAIL stall_count: got %0d want 4", got); end
        eng_done = 1'b1;
        step();
        checks++; if (req_done !== 2'b01) begin errors++; $display("FAIL stall_done: got %b want 01", req_done); end
        req_start = '0;
        eng_done  = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic test_cfg_zero();
        req_cfg_k = {16'd0, 16'd3};
        req_start = 2'b10;
        step();
        checks++; if (req_grant !== 2'b10 || req_err !== 2'b10) begin errors++; $display("FAIL zero_load: grant %b err %b want 10 10", req_grant, req_err); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL zero_start_load: got %b want 0", eng_start); end
        req_start = '0;
        step();
        checks++; if (req_err !== 2'b00 || req_grant !== 2'b00 || eng_start !== 1'b0) begin
            errors++; $display("FAIL zero_idle: err %b grant %b start %b want 00 00 0", req_err, req_grant, eng_start); end
        req_start = 2'b01;
        step();
        checks++; if (req_grant !== 2'b01 || req_err !== 2'b00 || eng_cfg_k !== 16'd3) begin
            errors++; $display("FAIL zero_next_grant: grant %b err %b k %0d want 01 00 3", req_grant, req_err, eng_cfg_k); end
        step();
        checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL zero_next_start: got %b want 1", eng_start); end
        eng_done = 1'b1;
        step();
        req_start = '0;
        eng_done  = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic test_timeout();
        req_cfg_k = {16'd0, 16'd5};
        req_start = 2'b01;
        repeat (2) step();
        for (int k = 1; k < TIMEOUT_CYC; k++) begin
            step();
            checks++; if (req_err !== 2'b00 || eng_start !== 1'b1) begin
                errors++; $display("FAIL wd_early: cycle %0d err %b start %b want 00 1", k, req_err, eng_start); end
        end
        step();
        checks++; if (req_err !== 2'b01 || req_done !== 2'b00 || eng_start !== 1'b0) begin
            errors++; $display("FAIL wd_fire: err %b done %b start %b want 01 00 0", req_err, req_done, eng_start); end
        req_start = '0;
        eng_done  = 1'b1;
        repeat (2) step();
        checks++; if (req_grant !== 2'b01 || req_err !== 2'b00 || req_done !== 2'b00) begin
            errors++; $display("FAIL wd_hold: grant %b err %b done %b want 01 00 00", req_grant, req_err, req_done); end
        eng_done = 1'b0;
        step();
        checks++; if (req_grant !== 2'b00) begin errors++; $display("FAIL wd_release: grant %b want 00", req_grant); end
        req_start = 2'b01;
        repeat (2) step();
        repeat (TIMEOUT_CYC - 1) step();
        eng_done = 1'b1;
        step();
        checks++; if (req_done !== 2'b01 || req_err !== 2'b00) begin
            errors++; $display("FAIL wd_tie: done %b err %b want 01 00", req_done, req_err); end
        req_start = '0;
        eng_done  = 1'b0;
        step();
        checks++; if (req_grant !== 2'b00) begin errors++; $display("FAIL wd_tie_idle: grant %b want 00", req_grant); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        req_cfg_k = {16'd7, 16'd0};
        req_start = 2'b10;
        repeat (2) step();
        s_axis_a_tvalid = 2'b11; m_axis_a_tready = 1'b1;
        s_axis_c_tvalid = 1'b1;  m_axis_c_tready = 2'b11;
        #1;
        checks++; if (s_axis_a_tready !== 2'b10 || eng_start !== 1'b1) begin
            errors++; $display("FAIL mid_pre: a_rdy %b start %b want 10 1", s_axis_a_tready, eng_start); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (req_grant !== 2'b00 || eng_start !== 1'b0) begin
            errors++; $display("FAIL mid_async: grant %b start %b want 00 0", req_grant, eng_start); end
        checks++; if (m_axis_a_tvalid !== 1'b0 || s_axis_a_tready !== 2'b00 || s_axis_c_tready !== 1'b0 || m_axis_c_tvalid !== 2'b00) begin
            errors++; $display("FAIL mid_streams: a_vld %b a_rdy %b c_rdy %b c_vld %b want 0", m_axis_a_tvalid, s_axis_a_tready, s_axis_c_tready, m_axis_c_tvalid); end
        checks++; if (req_done !== 2'b00 || req_err !== 2'b00) begin
            errors++; $display("FAIL mid_pulses: done %b err %b want 00 00", req_done, req_err); end
        idle_inputs();
        step();
        rst_n     = 1'b1;
        req_cfg_k = {16'd2, 16'd3};
        req_start = 2'b11;
        step();
        checks++; if (req_grant !== 2'b01) begin errors++; $display("FAIL mid_regrant: grant %b want 01", req_grant); end
        step();
        eng_done = 1'b1;
        step();
        req_start = '0;
        eng_done  = 1'b0;
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        apply_reset();
        test_reset();
        test_single_job();
        test_round_robin();
        test_c_stall();
        test_cfg_zero();
        test_timeout();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
